// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store sequencer for a word-addressed memory.
// Word-crossing accesses become two sequential word accesses.
module lsu_ctrl #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [29:0] mem_raddr,
    input  logic [31:0] mem_rval,
    output logic [29:0] mem_waddr,
    output logic [31:0] mem_wval,
    output logic [3:0]  mem_byte_en,
    output logic        mem_we
);

    // RESP is folded into IDLE: the registered response pulse
    // overlaps the idle cycle so a new request can be taken.
    typedef enum logic [2:0] {
        IDLE, LD_HI, LD_DONE, ST_HI, RESP
    } state_t;

    state_t      state, next;

    logic [1:0]  off;
    logic [2:0]  size;
    logic [7:0]  base;
    logic [7:0]  mask;
    logic [63:0] wide;
    logic        mis;
    logic        legal;
    logic        reject;
    logic        accept;

    logic [29:0] word_q;
    logic [29:0] raddr_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        mis_q;
    logic [3:0]  hi_be_q;
    logic [31:0] hi_wd_q;
    logic [31:0] lo_q;

    logic [63:0] pair;
    logic [31:0] ld_word;
    logic [31:0] ld_data;

    assign off    = req_addr[1:0];
    assign mis    = ({1'b0, off} + size) > 3'd4;
    assign legal  = req_we ? (req_funct3 <= 3'd2)
                           : (req_funct3 <= 3'd2 ||
                              req_funct3 == 3'd4 ||
                              req_funct3 == 3'd5);
    assign reject = !legal || (mis && !ALLOW_MISALIGNED);
    assign accept = req_valid && req_ready;
    assign wide   = {32'b0, req_wdata} << {off, 3'b000};
    assign mem_we = |mem_byte_en;

    // Request decode: access size and two-word lane mask
    always_comb begin
        size = 3'd4;
        base = 8'h0F;
        case (req_funct3[1:0])
            2'd0: begin size = 3'd1; base = 8'h01; end
            2'd1: begin size = 3'd2; base = 8'h03; end
            default: ;
        endcase
        mask = base << off;
    end

    // Load result: shift the word pair into place, then extend
    always_comb begin
        pair    = mis_q ? {mem_rval, lo_q} : {32'b0, mem_rval};
        ld_word = 32'(pair >> {off_q, 3'b000});
        case (f3_q)
            3'd0:    ld_data = {{24{ld_word[7]}}, ld_word[7:0]};
            3'd1:    ld_data = {{16{ld_word[15]}}, ld_word[15:0]};
            3'd4:    ld_data = {24'b0, ld_word[7:0]};
            3'd5:    ld_data = {16'b0, ld_word[15:0]};
            default: ld_data = ld_word;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    // Next state and memory-side outputs
    always_comb begin
        next        = state;
        req_ready   = 1'b0;
        mem_raddr   = raddr_q;
        mem_waddr   = word_q + 30'd1;
        mem_wval    = hi_wd_q;
        mem_byte_en = 4'b0;
        case (state)
            IDLE: begin
                req_ready = rst_n;
                mem_raddr = req_addr[31:2];
                mem_waddr = req_addr[31:2];
                mem_wval  = wide[31:0];
                if (accept) begin
                    if (reject) begin
                        next = IDLE;
                    end else if (req_we) begin
                        mem_byte_en = mask[3:0];
                        next = mis ? ST_HI : IDLE;
                    end else begin
                        next = mis ? LD_HI : LD_DONE;
                    end
                end
            end
            LD_HI: begin
                mem_raddr = word_q + 30'd1;
                next      = LD_DONE;
            end
            LD_DONE: next = IDLE;
            ST_HI: begin
                mem_byte_en = hi_be_q;
                next        = IDLE;
            end
            default: next = IDLE;
        endcase
        if (!rst_n) mem_byte_en = 4'b0;
    end

    // Request capture, low-word capture and response pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q    <= '0;
            raddr_q   <= '0;
            off_q     <= '0;
            f3_q      <= '0;
            mis_q     <= 1'b0;
            hi_be_q   <= '0;
            hi_wd_q   <= '0;
            lo_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            raddr_q   <= mem_raddr;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        word_q  <= req_addr[31:2];
                        off_q   <= off;
                        f3_q    <= req_funct3;
                        mis_q   <= mis;
                        hi_be_q <= mask[7:4];
                        hi_wd_q <= wide[63:32];
                        if (reject) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else if (req_we && !mis) begin
                            rsp_valid <= 1'b1;
                        end
                    end
                end
                LD_HI: lo_q <= mem_rval;
                LD_DONE: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= ld_data;
                end
                ST_HI: rsp_valid <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: vector table, random ops against a byte-level model,
// and hand sequences for split, back-to-back and reset-abort cases.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [29:0] mem_raddr, mem_waddr;
    logic [31:0] mem_rval, mem_wval;
    logic [3:0]  mem_byte_en;
    logic        mem_we;

    logic        r0_valid, r0_ready, r0_we;
    logic [2:0]  r0_funct3;
    logic [31:0] r0_addr, r0_wdata;
    logic        r0_rsp_valid, r0_rsp_err;
    logic [31:0] r0_rsp_rdata;
    logic [29:0] r0_raddr, r0_waddr;
    logic [31:0] r0_rval = 32'h0;
    logic [31:0] r0_wval;
    logic [3:0]  r0_byte_en;
    logic        r0_mem_we;

    logic [31:0] mem [0:63];
    logic [7:0]  rb [0:255];
    logic        bd_we = 1'b0;
    logic [5:0]  bd_a;
    logic [31:0] bd_v;

    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.ALLOW_MISALIGNED(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .mem_raddr(mem_raddr), .mem_rval(mem_rval),
        .mem_waddr(mem_waddr), .mem_wval(mem_wval),
        .mem_byte_en(mem_byte_en), .mem_we(mem_we)
    );

    lsu_ctrl #(.ALLOW_MISALIGNED(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(r0_valid), .req_ready(r0_ready),
        .req_we(r0_we), .req_funct3(r0_funct3),
        .req_addr(r0_addr), .req_wdata(r0_wdata),
        .rsp_valid(r0_rsp_valid), .rsp_rdata(r0_rsp_rdata),
        .rsp_err(r0_rsp_err),
        .mem_raddr(r0_raddr), .mem_rval(r0_rval),
        .mem_waddr(r0_waddr), .mem_wval(r0_wval),
        .mem_byte_en(r0_byte_en), .mem_we(r0_mem_we)
    );

    // Word memory: synchronous read, byte-enabled write, backdoor load
    always @(posedge clk) begin
        mem_rval <= mem[mem_raddr[5:0]];
        if (mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_byte_en[b])
                    mem[mem_waddr[5:0]][8*b +: 8] <= mem_wval[8*b +: 8];
        if (bd_we) mem[bd_a] <= bd_v;
    end

    typedef struct {
        bit          we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        int          pw0;
        logic [31:0] pv0;
        int          pw1;
        logic [31:0] pv1;
        logic [31:0] rd;
        bit          err;
        int          lat;
        logic [3:0]  be;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_word(input int w, input logic [31:0] v);
        @(negedge clk);
        bd_we = 1'b1;
        bd_a  = 6'(w);
        bd_v  = v;
        for (int b = 0; b < 4; b++) rb[4*w + b] = v[8*b +: 8];
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    // Byte-addressed reference: what the access means, not how it is split
    function automatic void ref_access(
        input bit we, input logic [2:0] f3, input logic [31:0] a,
        input logic [31:0] wd, output logic [31:0] rd,
        output bit err, output int lat);
        int s;
        bit legal, mis;
        logic [31:0] v;
        logic [7:0] idx;
        s = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 <= 3'd2)
                   : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        mis = (int'(a[1:0]) + s) > 4;
        rd = '0; err = 1'b0; lat = 1; v = '0;
        if (!legal) begin
            err = 1'b1;
            return;
        end
        for (int i = 0; i < s; i++) begin
            idx = a[7:0] + 8'(i);
            if (we) rb[idx] = wd[8*i +: 8];
            else    v[8*i +: 8] = rb[idx];
        end
        if (we) begin
            lat = mis ? 2 : 1;
        end else begin
            lat = mis ? 3 : 2;
            case (f3)
                3'd0:    rd = {{24{v[7]}}, v[7:0]};
                3'd1:    rd = {{16{v[15]}}, v[15:0]};
                default: rd = v;
            endcase
        end
    endfunction

    task automatic run(input bit sel, input bit we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output bit err,
                       output int lat, output logic [3:0] be);
        int n;
        @(negedge clk);
        if (sel) begin
            r0_we = we; r0_funct3 = f3; r0_addr = a;
            r0_wdata = wd; r0_valid = 1'b1;
        end else begin
            req_we = we; req_funct3 = f3; req_addr = a;
            req_wdata = wd; req_valid = 1'b1;
        end
        #1;
        n = 0;
        while (!(sel ? r0_ready : req_ready) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            checks++; fails++;
            $display("FAIL ready_timeout: got 0 expected 1");
        end
        be = sel ? r0_byte_en : mem_byte_en;
        @(posedge clk);
        #1;
        r0_valid = 1'b0;
        req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            be |= sel ? r0_byte_en : mem_byte_en;
        end while (!(sel ? r0_rsp_valid : rsp_valid) && lat < 10);
        if (!(sel ? r0_rsp_valid : rsp_valid)) begin
            checks++; fails++;
            $display("FAIL rsp_timeout: got 0 expected 1");
        end
        rd  = sel ? r0_rsp_rdata : rsp_rdata;
        err = sel ? r0_rsp_err : rsp_err;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, erd;
        bit          err, eerr;
        int          lat, elat;
        logic [3:0]  be;
        bit          we;
        logic [2:0]  f3;
        logic [31:0] a, wd;

        tbl[0]  = '{0, 0, 'h41, 0, 16, 'h8899AABB, 17, 'h88776655,
                    'hFFFFFFAA, 0, 2, 0};
        tbl[1]  = '{0, 2, 'h43, 0, 16, 'h44332211, -1, 0,
                    'h77665544, 0, 3, 0};
        tbl[2]  = '{0, 5, 'h43, 0, -1, 0, -1, 0, 'h00005544, 0, 3, 0};
        tbl[3]  = '{0, 1, 'h42, 0, -1, 0, -1, 0, 'h00004433, 0, 2, 0};
        tbl[4]  = '{0, 0, 'h47, 0, -1, 0, -1, 0, 'hFFFFFF88, 0, 2, 0};
        tbl[5]  = '{0, 4, 'h47, 0, -1, 0, -1, 0, 'h00000088, 0, 2, 0};
        tbl[6]  = '{0, 1, 'h46, 0, -1, 0, -1, 0, 'hFFFF8877, 0, 2, 0};
        tbl[7]  = '{0, 2, 'h44, 0, -1, 0, -1, 0, 'h88776655, 0, 2, 0};
        tbl[8]  = '{0, 3, 'h40, 0, -1, 0, -1, 0, 0, 1, 1, 0};
        tbl[9]  = '{1, 4, 'h40, 'hFFFFFFFF, -1, 0, -1, 0, 0, 1, 1, 0};
        tbl[10] = '{0, 6, 'h41, 0, -1, 0, -1, 0, 0, 1, 1, 0};
        tbl[11] = '{1, 2, 'h50, 'h11223344, 20, 0, 21, 0, 0, 0, 1, 'hF};
        tbl[12] = '{1, 0, 'h51, 'hFFFFFFA5, -1, 0, -1, 0, 0, 0, 1, 'h2};
        tbl[13] = '{1, 1, 'h53, 'h1234BEEF, -1, 0, -1, 0, 0, 0, 2, 'h9};
        tbl[14] = '{0, 2, 'h50, 0, -1, 0, -1, 0, 'hEF22A544, 0, 2, 0};
        tbl[15] = '{0, 5, 'h53, 0, -1, 0, -1, 0, 'h0000BEEF, 0, 3, 0};
        tbl[16] = '{0, 2, 'hFFFFFFFE, 0, 63, 'hA1B2C3D4, 0, 'h55667788,
                    'h7788A1B2, 0, 3, 0};

        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h0; req_wdata = 32'hFFFFFFFF;
        r0_valid = 1'b1; r0_we = 1'b1; r0_funct3 = 3'd2;
        r0_addr = 32'h0; r0_wdata = 32'hFFFFFFFF;

        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_byte_en", {28'b0, mem_byte_en}, 32'd0);
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_ready0", {31'b0, r0_ready}, 32'd0);
        req_valid = 1'b0;
        r0_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);

        for (int w = 0; w < 64; w++) set_word(w, $urandom);

        for (int i = 0; i < 17; i++) begin
            if (tbl[i].pw0 >= 0) set_word(tbl[i].pw0, tbl[i].pv0);
            if (tbl[i].pw1 >= 0) set_word(tbl[i].pw1, tbl[i].pv1);
            ref_access(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd,
                       erd, eerr, elat);
            run(1'b0, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd,
                rd, err, lat, be);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
            chk($sformatf("vec%0d_err", i), {31'b0, err},
                {31'b0, tbl[i].err});
            chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
            chk($sformatf("vec%0d_be", i), {28'b0, be},
                {28'b0, tbl[i].be});
        end

        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            wd = $urandom;
            ref_access(we, f3, a, wd, erd, eerr, elat);
            run(1'b0, we, f3, a, wd, rd, err, lat, be);
            chk($sformatf("rnd%0d_rdata", i), rd, erd);
            chk($sformatf("rnd%0d_err", i), {31'b0, err}, {31'b0, eerr});
            chk($sformatf("rnd%0d_lat", i), lat, elat);
        end

        set_word(17, 32'h11111111);
        set_word(18, 32'h22222222);
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h46; req_wdata = 32'hDEADBEEF;
        req_valid = 1'b1;
        #1;
        chk("swm_ready", {31'b0, req_ready}, 32'd1);
        chk("swm_be_lo", {28'b0, mem_byte_en}, 32'hC);
        chk("swm_waddr_lo", {2'b0, mem_waddr}, 32'h11);
        chk("swm_wval_lo", mem_wval, 32'hBEEF0000);
        chk("swm_we_lo", {31'b0, mem_we}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("swm_be_hi", {28'b0, mem_byte_en}, 32'h3);
        chk("swm_waddr_hi", {2'b0, mem_waddr}, 32'h12);
        chk("swm_wval_hi", mem_wval, 32'h0000DEAD);
        chk("swm_no_rsp", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("swm_rsp", {31'b0, rsp_valid}, 32'd1);
        chk("swm_rdata", rsp_rdata, 32'd0);
        chk("swm_err", {31'b0, rsp_err}, 32'd0);
        chk("swm_mem_lo", mem[17], 32'hBEEF1111);
        chk("swm_mem_hi", mem[18], 32'h2222DEAD);

        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'd0;
        req_addr = 32'h41; req_wdata = 32'h0000005A;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("b2b_rsp1", {31'b0, rsp_valid}, 32'd1);
        chk("b2b_ready", {31'b0, req_ready}, 32'd1);
        req_we = 1'b0; req_funct3 = 3'd4;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 10);
        chk("b2b_lat", lat, 32'd2);
        chk("b2b_rdata", rsp_rdata, 32'h0000005A);
        chk("b2b_err", {31'b0, rsp_err}, 32'd0);

        set_word(17, 32'h11111111);
        set_word(18, 32'h22222222);
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h46; req_wdata = 32'hDEADBEEF;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("abort_be", {28'b0, mem_byte_en}, 32'd0);
        chk("abort_we", {31'b0, mem_we}, 32'd0);
        chk("abort_ready", {31'b0, req_ready}, 32'd0);
        chk("abort_rsp", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("abort_rsp2", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("abort_mem_hi", mem[18], 32'h22222222);
        chk("abort_mem_lo", mem[17], 32'hBEEF1111);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready_after", {31'b0, req_ready}, 32'd1);
        chk("abort_rsp3", {31'b0, rsp_valid}, 32'd0);
        run(1'b0, 1'b0, 3'd2, 32'h44, 32'h0, rd, err, lat, be);
        chk("abort_lw_rdata", rd, 32'hBEEF1111);
        chk("abort_lw_err", {31'b0, err}, 32'd0);
        chk("abort_lw_lat", lat, 32'd2);

        run(1'b1, 1'b1, 3'd1, 32'h3, 32'h1234, rd, err, lat, be);
        chk("nm_sh_err", {31'b0, err}, 32'd1);
        chk("nm_sh_rdata", rd, 32'd0);
        chk("nm_sh_lat", lat, 32'd1);
        chk("nm_sh_be", {28'b0, be}, 32'd0);
        run(1'b1, 1'b0, 3'd3, 32'h0, 32'h0, rd, err, lat, be);
        chk("nm_f3_err", {31'b0, err}, 32'd1);
        chk("nm_f3_rdata", rd, 32'd0);
        chk("nm_f3_be", {28'b0, be}, 32'd0);
        run(1'b1, 1'b0, 3'd2, 32'h1, 32'h0, rd, err, lat, be);
        chk("nm_lw_err", {31'b0, err}, 32'd1);
        chk("nm_lw_lat", lat, 32'd1);
        run(1'b1, 1'b1, 3'd2, 32'h8, 32'h12345678, rd, err, lat, be);
        chk("nm_sw_err", {31'b0, err}, 32'd0);
        chk("nm_sw_be", {28'b0, be}, 32'hF);
        chk("nm_sw_lat", lat, 32'd1);
        run(1'b1, 1'b0, 3'd0, 32'h1, 32'h0, rd, err, lat, be);
        chk("nm_lb_err", {31'b0, err}, 32'd0);
        chk("nm_lb_lat", lat, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
